// File: rtl/sram_arb_pkg.sv
// Shared types and default sizing for the two-port SRAM arbiter.
// The optional round-robin mode is selected by SRAM_ARB_RR_EN (see sram_arb.sv).
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    localparam int DEF_AW       = 4;
    localparam int DEF_DW       = 8;
    localparam int DEF_LOCK_MAX = 8;

    // One-hot encoding of a port index: 0 -> 2'b01, 1 -> 2'b10.
    function automatic logic [1:0] onehot_port(input logic port);
        return port ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/sram_arb_pick.sv
// Two-way winner selection: a lone requester always wins; under contention a
// pending forced winner takes precedence, otherwise the port not named by ptr_i wins.
module sram_arb_pick (
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    input  logic [1:0] force_i,
    output logic [1:0] win_o
);

    always_comb begin
        win_o = req_i;
        if (req_i == 2'b11) begin
            if (force_i != 2'b00) begin
                win_o = force_i;
            end else begin
                win_o = ptr_i ? 2'b01 : 2'b10;
            end
        end
    end

endmodule

// File: rtl/sram_arb.sv
// Two-port arbiter in front of a single-port registered-read SRAM, with per-port
// bus locking. Define SRAM_ARB_RR_EN for round-robin contention; default is port-0 priority.
module sram_arb
    import sram_arb_pkg::*;
#(
    parameter int AW       = DEF_AW,
    parameter int DW       = DEF_DW,
    parameter int LOCK_MAX = DEF_LOCK_MAX
) (
    input  logic          clk_i,
    input  logic          rst_n_i,

    input  logic          req0_i,
    input  logic          we0_i,
    input  logic [AW-1:0] addr0_i,
    input  logic [DW-1:0] wdata0_i,
    input  logic          lock0_i,
    output logic          gnt0_o,
    output logic          rvalid0_o,
    output logic [DW-1:0] rdata0_o,

    input  logic          req1_i,
    input  logic          we1_i,
    input  logic [AW-1:0] addr1_i,
    input  logic [DW-1:0] wdata1_i,
    input  logic          lock1_i,
    output logic          gnt1_o,
    output logic          rvalid1_o,
    output logic [DW-1:0] rdata1_o,

    output logic [AW-1:0] sram_addr_o,
    output logic [DW-1:0] sram_wdata_o,
    output logic          sram_wren_o,
    input  logic [DW-1:0] sram_rdata_i
);

    localparam int            CW         = $clog2(LOCK_MAX + 1);
    localparam logic [CW-1:0] LOCK_MAX_C = CW'(LOCK_MAX);
    localparam logic [CW-1:0] ONE_C      = CW'(1);

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_inc;
    logic [1:0]    force_q;
    logic [1:0]    rvalid_q;

    logic [1:0]    req;
    logic [1:0]    lock;
    logic [1:0]    we;
    logic [1:0]    win;
    logic [1:0]    gnt;
    logic [1:0]    rvalid;
    logic [DW-1:0] rdata [2];
    logic          ptr;
    logic          own_port;

    assign req      = {req1_i, req0_i};
    assign lock     = {lock1_i, lock0_i};
    assign we       = {we1_i, we0_i};
    assign own_port = (state_q == OWN1);
    assign cnt_inc  = cnt_q + ONE_C;

`ifdef SRAM_ARB_RR_EN
    logic last_q;

    // Remembers the most recently granted port; updated on every grant.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            last_q <= 1'b1;
        end else if (gnt[0]) begin
            last_q <= 1'b0;
        end else if (gnt[1]) begin
            last_q <= 1'b1;
        end
    end

    assign ptr = last_q;
`else
    // Pretending port 1 was last granted makes port 0 the fixed winner.
    assign ptr = 1'b1;
`endif

    sram_arb_pick u_pick (
        .req_i   (req),
        .ptr_i   (ptr),
        .force_i (force_q),
        .win_o   (win)
    );

    always_comb begin
        gnt = 2'b00;
        if (rst_n_i) begin
            case (state_q)
                IDLE:    gnt = win;
                OWN0:    gnt = {1'b0, req0_i};
                OWN1:    gnt = {req1_i, 1'b0};
                default: gnt = 2'b00;
            endcase
        end
    end

    always_comb begin
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        sram_wren_o  = 1'b0;
        if (gnt[0]) begin
            sram_addr_o  = addr0_i;
            sram_wdata_o = wdata0_i;
            sram_wren_o  = we0_i;
        end else if (gnt[1]) begin
            sram_addr_o  = addr1_i;
            sram_wdata_o = wdata1_i;
            sram_wren_o  = we1_i;
        end
    end

    // Ownership FSM; force_q holds the port owed the next contended IDLE cycle
    // after an owner was cut off at LOCK_MAX.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            force_q <= 2'b00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req == 2'b11) begin
                        force_q <= 2'b00;
                    end
                    if (gnt[0] && lock0_i) begin
                        if (LOCK_MAX_C == ONE_C) begin
                            force_q <= onehot_port(1'b1);
                        end else begin
                            state_q <= OWN0;
                            cnt_q   <= ONE_C;
                        end
                    end else if (gnt[1] && lock1_i) begin
                        if (LOCK_MAX_C == ONE_C) begin
                            force_q <= onehot_port(1'b0);
                        end else begin
                            state_q <= OWN1;
                            cnt_q   <= ONE_C;
                        end
                    end
                end
                OWN0, OWN1: begin
                    if (!req[own_port] || !lock[own_port] || cnt_inc == LOCK_MAX_C) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        if (req[own_port] && cnt_inc == LOCK_MAX_C) begin
                            force_q <= onehot_port(~own_port);
                        end
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rvalid_q <= 2'b00;
        end else begin
            rvalid_q <= gnt & ~we;
        end
    end

    // Gating with rst_n_i drops a response whose read landed just before reset.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_resp
            assign rvalid[gi] = rvalid_q[gi] & rst_n_i;
            assign rdata[gi]  = rvalid[gi] ? sram_rdata_i : '0;
        end
    endgenerate

    assign gnt0_o    = gnt[0];
    assign gnt1_o    = gnt[1];
    assign rvalid0_o = rvalid[0];
    assign rvalid1_o = rvalid[1];
    assign rdata0_o  = rdata[0];
    assign rdata1_o  = rdata[1];

endmodule

// File: tb/tb_sram_arb.sv
// Testbench for sram_arb: directed scenarios with literal expectations, then random
// traffic compared each cycle against a transaction-level arbitration model.
module tb_sram_arb;

    localparam int AW       = 4;
    localparam int DW       = 8;
    localparam int LOCK_MAX = 8;
`ifdef SRAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0 = 1'b0, we0 = 1'b0, lock0 = 1'b0;
    logic          req1 = 1'b0, we1 = 1'b0, lock1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic          sram_wren;
    logic [DW-1:0] sram_rdata = '0;
    logic [DW-1:0] sram_mem [2**AW];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sram_arb #(.AW(AW), .DW(DW), .LOCK_MAX(LOCK_MAX)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .req0_i       (req0),
        .we0_i        (we0),
        .addr0_i      (addr0),
        .wdata0_i     (wdata0),
        .lock0_i      (lock0),
        .gnt0_o       (gnt0),
        .rvalid0_o    (rvalid0),
        .rdata0_o     (rdata0),
        .req1_i       (req1),
        .we1_i        (we1),
        .addr1_i      (addr1),
        .wdata1_i     (wdata1),
        .lock1_i      (lock1),
        .gnt1_o       (gnt1),
        .rvalid1_o    (rvalid1),
        .rdata1_o     (rdata1),
        .sram_addr_o  (sram_addr),
        .sram_wdata_o (sram_wdata),
        .sram_wren_o  (sram_wren),
        .sram_rdata_i (sram_rdata)
    );

    // Single-port SRAM with registered read data.
    always @(posedge clk) begin
        if (sram_wren) sram_mem[sram_addr] <= sram_wdata;
        sram_rdata <= sram_mem[sram_addr];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: who owns the bus, how many grants it has had, who was
    // granted last, who is owed the next contended cycle, and pending reads.
    int            m_owner = -1;
    int            m_cnt   = 0;
    int            m_last  = 1;
    int            m_pref  = -1;
    bit            m_pend [2];
    logic [DW-1:0] m_rdv  [2];
    logic [DW-1:0] m_mem  [2**AW];

    int            eg;
    logic [1:0]    rq;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic          ew, lk;

    always @(negedge clk) begin
        rq = {req1, req0};
        eg = -1;
        if (rst_n) begin
            if (m_owner >= 0) begin
                if (rq[m_owner]) eg = m_owner;
            end else if (rq == 2'b11) begin
                eg = (m_pref >= 0) ? m_pref : (RR ? 1 - m_last : 0);
            end else if (rq[0]) begin
                eg = 0;
            end else if (rq[1]) begin
                eg = 1;
            end
        end
        ea = (eg == 0) ? addr0  : (eg == 1) ? addr1  : '0;
        ed = (eg == 0) ? wdata0 : (eg == 1) ? wdata1 : '0;
        ew = (eg == 0) ? we0    : (eg == 1) ? we1    : 1'b0;
        lk = (eg == 0) ? lock0  : (eg == 1) ? lock1  : 1'b0;

        chk("gnt0", gnt0, (eg == 0));
        chk("gnt1", gnt1, (eg == 1));
        chk("sram_addr", sram_addr, ea);
        chk("sram_wdata", sram_wdata, ed);
        chk("sram_wren", sram_wren, ew);
        chk("rvalid0", rvalid0, rst_n && m_pend[0]);
        chk("rvalid1", rvalid1, rst_n && m_pend[1]);
        chk("rdata0", rdata0, (rst_n && m_pend[0]) ? m_rdv[0] : '0);
        chk("rdata1", rdata1, (rst_n && m_pend[1]) ? m_rdv[1] : '0);

        m_pend[0] = 1'b0;
        m_pend[1] = 1'b0;
        if (!rst_n) begin
            m_owner = -1;
            m_cnt   = 0;
            m_last  = 1;
            m_pref  = -1;
        end else begin
            if (m_owner < 0 && rq == 2'b11) m_pref = -1;
            if (eg >= 0) begin
                m_last = eg;
                if (ew) begin
                    m_mem[ea] = ed;
                end else begin
                    m_pend[eg] = 1'b1;
                    m_rdv[eg]  = m_mem[ea];
                end
                if (m_owner < 0) begin
                    if (lk) begin
                        m_owner = eg;
                        m_cnt   = 1;
                    end
                end else begin
                    m_cnt++;
                end
                if (m_owner >= 0 && m_cnt == LOCK_MAX) begin
                    m_pref  = 1 - eg;
                    m_owner = -1;
                    m_cnt   = 0;
                end else if (m_owner >= 0 && !lk) begin
                    m_owner = -1;
                    m_cnt   = 0;
                end
            end else if (m_owner >= 0) begin
                m_owner = -1;
                m_cnt   = 0;
            end
        end
    end

    task automatic idle_in();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lp;
        for (int a = 0; a < 2**AW; a++) begin
            sram_mem[a] = '0;
            m_mem[a]    = '0;
        end
        idle_in();
        rst_n = 0;
        #1;

        // Requests during reset must not be granted or reach the SRAM.
        req0 = 1; req1 = 1; we0 = 1; addr0 = 4'h7; wdata0 = 8'h3C;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_gnt", {gnt1, gnt0}, 0);
            chk("rst_wren", sram_wren, 0);
            chk("rst_rvalid", {rvalid1, rvalid0}, 0);
            nxt();
        end

        // Write 0xA5 to address 3, then read it back on the next cycle.
        rst_n = 1; idle_in();
        req0 = 1; we0 = 1; addr0 = 4'd3; wdata0 = 8'hA5;
        @(negedge clk); chk("wr_gnt0", gnt0, 1); chk("wr_sram_wdata", sram_wdata, 8'hA5);
        nxt();
        we0 = 0;
        @(negedge clk); chk("rd_gnt0", gnt0, 1); chk("rd_sram_addr", sram_addr, 4'd3);
        nxt();
        idle_in();
        @(negedge clk); chk("rd_rvalid0", rvalid0, 1); chk("rd_rdata0", rdata0, 8'hA5);
        nxt();

        // Constant contention straight after reset.
        rst_n = 0; nxt(); rst_n = 1;
        req0 = 1; req1 = 1; addr0 = 4'd3; addr1 = 4'd3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("cont_gnt0", gnt0, RR ? (i % 2 == 0) : 1);
            chk("cont_gnt1", gnt1, RR ? (i % 2 == 1) : 0);
            nxt();
        end

        // Port 1 locks and is held for exactly LOCK_MAX grants, then port 0 wins.
        idle_in(); rst_n = 0; nxt(); rst_n = 1;
        req1 = 1; lock1 = 1; addr1 = 4'd5;
        for (int i = 0; i < LOCK_MAX; i++) begin
            @(negedge clk); chk("lock_gnt1", gnt1, 1); chk("lock_gnt0", gnt0, 0);
            nxt();
            req0 = 1;
        end
        @(negedge clk); chk("lock_rel_gnt0", gnt0, 1); chk("lock_rel_gnt1", gnt1, 0);
        nxt();

        // Read granted, then reset on the following cycle: response is dropped.
        idle_in(); nxt();
        req0 = 1; addr0 = 4'd3;
        @(negedge clk); chk("drop_gnt0", gnt0, 1);
        nxt();
        idle_in(); rst_n = 0;
        @(negedge clk); chk("drop_rvalid_rst", rvalid0, 0);
        nxt();
        rst_n = 1;
        @(negedge clk);
        chk("drop_rvalid_after", rvalid0, 0);
        chk("drop_outs", {gnt1, gnt0, sram_wren, sram_addr, sram_wdata, rdata0}, 0);
        nxt();

        // Random traffic, alternating light locking with long sticky lock bursts.
        for (int n = 0; n < 2000; n++) begin
            lp    = ((n / 100) % 2 == 1) ? 95 : 40;
            rst_n = ($urandom_range(0, 199) != 0);
            req0  = ($urandom_range(0, 99) < 75);
            req1  = ($urandom_range(0, 99) < 75);
            lock0 = ($urandom_range(0, 99) < lp);
            lock1 = ($urandom_range(0, 99) < lp);
            we0   = $urandom_range(0, 1) == 1;
            we1   = $urandom_range(0, 1) == 1;
            addr0 = AW'($urandom_range(0, 2**AW - 1));
            addr1 = AW'($urandom_range(0, 2**AW - 1));
            wdata0 = DW'($urandom);
            wdata1 = DW'($urandom);
            nxt();
        end

        idle_in();
        rst_n = 1;
        nxt();
        nxt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
